// File: rtl/dmem_be_if.sv
// -----------------------------------------------------------------------------
// dmem_be_if -- request/response bundle between the MEM stage and dmem_be.
//
// Parameters: DATA_W (word width, multiple of 8), ADDR_W (byte-address width).
// Signals:
//   req, we, a, wd, be           request side, driven by the master (CPU)
//   rd, rvalid, ready,           response side, driven by the slave (memory)
//   misalign, oor
// Modports: master (CPU side), slave (memory side).
// -----------------------------------------------------------------------------
interface dmem_be_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    localparam int BYTES = DATA_W / 8;

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] wd;
    logic [BYTES-1:0]  be;
    logic [DATA_W-1:0] rd;
    logic              rvalid;
    logic              ready;
    logic              misalign;
    logic              oor;

    modport master (
        output req, we, a, wd, be,
        input  rd, rvalid, ready, misalign, oor
    );

    modport slave (
        input  req, we, a, wd, be,
        output rd, rvalid, ready, misalign, oor
    );
endinterface

// File: rtl/dmem_be.sv
// -----------------------------------------------------------------------------
// dmem_be -- byte-enabled data memory for the MEM stage of the pipelined CPU.
//
// One access per cycle. Writes honour per-byte lane enables; reads return data
// RD_LAT (1 or 2) cycles after acceptance with a one-cycle rvalid pulse.
// Misaligned or out-of-range accesses suppress writes, return zero on reads and
// raise one-cycle misalign/oor pulses the cycle after acceptance.
//
// Parameters: DATA_W, DEPTH (power of two), ADDR_W, RD_LAT (1|2), INIT_FILE.
// Ports:
//   clk    clock, all state on the rising edge
//   rst_n  asynchronous active-low reset (memory array itself is not reset)
//   bus    dmem_be_if.slave: req/we/a/wd/be in; rd/rvalid/ready/misalign/oor out
//
// Build option: define DMEM_CLEAR_EN to add a clear state machine that zeroes
// every word (one per cycle, DEPTH cycles) after reset release; ready stays low
// until the walk finishes. Without it, ready rises on the first edge after reset
// release and contents are undefined until written. INIT_FILE is not loaded by
// this block; a non-empty value only produces an elaboration warning.
// -----------------------------------------------------------------------------
module dmem_be #(
    parameter int    DATA_W    = 32,
    parameter int    DEPTH     = 64,
    parameter int    ADDR_W    = 32,
    parameter int    RD_LAT    = 1,
    parameter string INIT_FILE = ""
) (
    input  logic      clk,
    input  logic      rst_n,
    dmem_be_if.slave  bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);
    // Extra bit so DEPTH*BYTES is representable even when it equals 2**ADDR_W.
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH * BYTES);

    generate
        if (INIT_FILE != "") begin : g_init_note
            $warning("dmem_be: INIT_FILE is not preloaded by this block");
        end
    endgenerate

    logic [DATA_W-1:0] mem [DEPTH];

    logic              ready;
    logic              acc;
    logic              rd_acc;
    logic              misal;
    logic              oor_hit;
    logic              legal;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] rd_word;

    logic              clr_active;
    logic [IDX_W-1:0]  clr_idx;

    logic              mem_we;
    logic [IDX_W-1:0]  mem_idx;
    logic [DATA_W-1:0] mem_wd;
    logic [BYTES-1:0]  mem_be;
    logic [BYTES-1:0]  lane_we;

    logic [DATA_W-1:0] rd_reg;
    logic              rvalid_reg;
    logic              misalign_reg;
    logic              oor_reg;

    // ---------------------------------------------------------------- decode
    assign acc    = bus.req & ready;
    assign rd_acc = acc & ~bus.we;
    assign idx    = bus.a[OFF_W +: IDX_W];

    generate
        if (OFF_W > 0) begin : g_off
            assign misal = |bus.a[OFF_W-1:0];
        end else begin : g_no_off
            assign misal = 1'b0;
        end
    endgenerate

    assign oor_hit = ({1'b0, bus.a} >= LIMIT);
    assign legal   = ~misal & ~oor_hit;

    // ------------------------------------------------- ready / clear control
`ifdef DMEM_CLEAR_EN
    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [IDX_W-1:0] clr_idx_reg;
    logic [IDX_W-1:0] clr_idx_next;

    // Reset lands in CLEAR so an assertion mid-walk restarts it from word 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_CLEAR;
            clr_idx_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_idx_reg <= clr_idx_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clr_idx_next = clr_idx_reg;
        clr_active   = 1'b0;
        case (state_reg)
            S_CLEAR: begin
                clr_active   = 1'b1;
                clr_idx_next = clr_idx_reg + IDX_W'(1);
                if (clr_idx_reg == IDX_W'(DEPTH - 1)) begin
                    state_next = S_IDLE;
                end
            end
            S_IDLE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_CLEAR;
            end
        endcase
    end

    assign ready   = (state_reg == S_IDLE);
    assign clr_idx = clr_idx_reg;
`else
    logic ready_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_reg <= 1'b0;
        end else begin
            ready_reg <= 1'b1;
        end
    end

    assign ready      = ready_reg;
    assign clr_active = 1'b0;
    assign clr_idx    = '0;
`endif

    // ------------------------------------------------------------ write port
    // The clear walk owns the write port while active; bus accesses cannot be
    // accepted then because ready is low.
    always_comb begin
        mem_we  = 1'b0;
        mem_idx = idx;
        mem_wd  = bus.wd;
        mem_be  = bus.be;
        if (clr_active) begin
            mem_we  = 1'b1;
            mem_idx = clr_idx;
            mem_wd  = '0;
            mem_be  = '1;
        end else if (acc && bus.we && legal) begin
            mem_we  = 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
            assign lane_we[gi] = mem_we & mem_be[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < BYTES; i++) begin
            if (lane_we[i]) begin
                mem[mem_idx][i*8 +: 8] <= mem_wd[i*8 +: 8];
            end
        end
    end

    // ------------------------------------------------------------- read path
    // Illegal reads still complete, but with zero data.
    assign rd_word = legal ? mem[idx] : '0;

    generate
        if (RD_LAT == 1) begin : g_lat1
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_reg     <= '0;
                    rvalid_reg <= 1'b0;
                end else begin
                    rvalid_reg <= rd_acc;
                    if (rd_acc) begin
                        rd_reg <= rd_word;
                    end
                end
            end
        end else begin : g_lat2
            logic [DATA_W-1:0] p1_data_reg;
            logic              p1_vld_reg;

            // Data is captured at acceptance, so a later write cannot alter it.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    p1_data_reg <= '0;
                    p1_vld_reg  <= 1'b0;
                    rd_reg      <= '0;
                    rvalid_reg  <= 1'b0;
                end else begin
                    p1_vld_reg <= rd_acc;
                    if (rd_acc) begin
                        p1_data_reg <= rd_word;
                    end
                    rvalid_reg <= p1_vld_reg;
                    if (p1_vld_reg) begin
                        rd_reg <= p1_data_reg;
                    end
                end
            end
        end
    endgenerate

    // ----------------------------------------------------------- error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_reg <= 1'b0;
            oor_reg      <= 1'b0;
        end else begin
            misalign_reg <= acc & misal;
            oor_reg      <= acc & oor_hit;
        end
    end

    assign bus.rd       = rd_reg;
    assign bus.rvalid   = rvalid_reg;
    assign bus.ready    = ready;
    assign bus.misalign = misalign_reg;
    assign bus.oor      = oor_reg;
endmodule

// File: tb/tb_dmem_be.sv
// -----------------------------------------------------------------------------
// tb_dmem_be -- self-checking bench for dmem_be. Two instances (RD_LAT=1 and
// RD_LAT=2) receive identical stimulus; a byte-addressed reference memory and
// per-cycle request history predict every output after each rising edge.
// -----------------------------------------------------------------------------
module tb_dmem_be;
`ifdef DMEM_CLEAR_EN
    localparam int CLR = 1;
`else
    localparam int CLR = 0;
`endif
    localparam int DEPTH   = 64;
    localparam int NBYTES  = DEPTH * 4;
    localparam int HIST    = 4096;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dmem_be_if #(.DATA_W(32), .ADDR_W(32)) bus1 ();
    dmem_be_if #(.DATA_W(32), .ADDR_W(32)) bus2 ();

    dmem_be #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .RD_LAT(1), .INIT_FILE("")) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    dmem_be #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .RD_LAT(2), .INIT_FILE("")) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    // Reference state
    logic [7:0]  ref_mem [NBYTES];
    bit          hist_rd  [HIST];
    bit          hist_mis [HIST];
    bit          hist_oor [HIST];
    logic [31:0] hist_dat [HIST];
    int          cyc = 2;
    logic [31:0] last1 = '0;
    logic [31:0] last2 = '0;
    bit          ready_m = 1'b0;
    int          clr_cnt = 0;
    int          n_cmp = 0;
    int          n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s @cyc %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic drive(input bit req, input bit we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
        bus1.req = req; bus1.we = we; bus1.a = a; bus1.wd = wd; bus1.be = be;
        bus2.req = req; bus2.we = we; bus2.a = a; bus2.wd = wd; bus2.be = be;
    endtask

    task automatic check_all();
        bit e1;
        bit e2;
        e1 = hist_rd[cyc-1];
        e2 = hist_rd[cyc-2];
        if (e1) last1 = hist_dat[cyc-1];
        if (e2) last2 = hist_dat[cyc-2];
        chk("ready1",    32'(bus1.ready),    32'(ready_m));
        chk("ready2",    32'(bus2.ready),    32'(ready_m));
        chk("rvalid1",   32'(bus1.rvalid),   32'(e1));
        chk("rvalid2",   32'(bus2.rvalid),   32'(e2));
        chk("rd1",       bus1.rd,            last1);
        chk("rd2",       bus2.rd,            last2);
        chk("misalign1", 32'(bus1.misalign), 32'(hist_mis[cyc-1]));
        chk("misalign2", 32'(bus2.misalign), 32'(hist_mis[cyc-1]));
        chk("oor1",      32'(bus1.oor),      32'(hist_oor[cyc-1]));
        chk("oor2",      32'(bus2.oor),      32'(hist_oor[cyc-1]));
    endtask

    // One clock cycle with the given request presented.
    task automatic cycle(input bit req, input bit we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
        bit acc;
        bit legal;
        int base;
        drive(req, we, a, wd, be);
        acc   = req && ready_m;
        legal = (a % 4 == 0) && (a < NBYTES);
        base  = int'(a[7:0]);
        hist_rd[cyc]  = acc && !we;
        hist_mis[cyc] = acc && (a % 4 != 0);
        hist_oor[cyc] = acc && (a >= NBYTES);
        hist_dat[cyc] = '0;
        if (acc && !we && legal)
            hist_dat[cyc] = {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
        if (acc && we && legal)
            for (int i = 0; i < 4; i++)
                if (be[i]) ref_mem[base+i] = wd[8*i +: 8];
        if (acc)
            $display("txn cyc=%0d %s a=%h wd=%h be=%h", cyc, we ? "WR" : "RD", a, wd, be);
        @(posedge clk);
        #1;
        cyc++;
        if (CLR != 0) begin
            if (!ready_m) begin
                clr_cnt++;
                if (clr_cnt == DEPTH) begin
                    ready_m = 1'b1;
                    for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'h00;
                end
            end
        end else begin
            ready_m = 1'b1;
        end
        check_all();
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    // Assert reset mid-cycle, hold for n edges, release mid-cycle.
    task automatic do_reset(input int n);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        rst_n = 1'b0;
        #1;
        hist_rd[cyc-1] = 1'b0;   // in-flight reads are dropped
        last1 = '0;
        last2 = '0;
        ready_m = 1'b0;
        clr_cnt = 0;
        chk("rst_rd1",     bus1.rd,            32'h0);
        chk("rst_rd2",     bus2.rd,            32'h0);
        chk("rst_rvalid1", 32'(bus1.rvalid),   32'h0);
        chk("rst_rvalid2", 32'(bus2.rvalid),   32'h0);
        chk("rst_ready1",  32'(bus1.ready),    32'h0);
        chk("rst_ready2",  32'(bus2.ready),    32'h0);
        chk("rst_mis1",    32'(bus1.misalign), 32'h0);
        chk("rst_oor1",    32'(bus1.oor),      32'h0);
        for (int k = 0; k < n; k++) begin
            hist_rd[cyc] = 1'b0; hist_mis[cyc] = 1'b0; hist_oor[cyc] = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
            check_all();
        end
        rst_n = 1'b1;
    endtask

    task automatic wait_ready(input int exp_cycles);
        int count;
        count = 0;
        while (bus1.ready !== 1'b1 && count < 200) begin
            cycle(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);   // requests must be ignored
            count++;
        end
        chk("ready_wait", 32'(count), 32'(exp_cycles));
    endtask

    initial begin
        logic [31:0] a;
        int kind;

        do_reset(3);
        wait_ready(CLR != 0 ? DEPTH : 1);

`ifdef DMEM_CLEAR_EN
        // Clear walk: reads of cleared memory, then reset mid-clear restarts it.
        cycle(1'b1, 1'b0, 32'd0,   32'h0, 4'h0);
        cycle(1'b1, 1'b0, 32'd252, 32'h0, 4'h0);
        idle();
        chk("clr_rd252", bus1.rd, 32'h0);
        do_reset(1);
        for (int k = 0; k < 30; k++) idle();
        do_reset(1);
        wait_ready(DEPTH);
`endif

        // Fill every word so later reads are defined.
        for (int w = 0; w < DEPTH; w++)
            cycle(1'b1, 1'b1, 32'(w * 4), $urandom, 4'hF);

        // Defaults: writes at both ends, then reads.
        cycle(1'b1, 1'b1, 32'd0,   32'd10, 4'hF);
        cycle(1'b1, 1'b1, 32'd252, 32'd11, 4'hF);
        cycle(1'b1, 1'b0, 32'd0,   32'h0,  4'h0);
        chk("t1_rd0", bus1.rd, 32'd10);
        cycle(1'b1, 1'b0, 32'd252, 32'h0,  4'h0);
        chk("t1_rd252", bus1.rd, 32'd11);
        idle();
        chk("t1_lat2_rd252", bus2.rd, 32'd11);

        // Byte lanes.
        cycle(1'b1, 1'b1, 32'd4, 32'hAABBCCDD, 4'hF);
        cycle(1'b1, 1'b1, 32'd4, 32'h00000011, 4'b0001);
        cycle(1'b1, 1'b0, 32'd4, 32'h0, 4'h0);
        chk("t2_merge", bus1.rd, 32'hAABBCC11);
        cycle(1'b1, 1'b1, 32'd4, 32'hFFFFFFFF, 4'h0);
        cycle(1'b1, 1'b0, 32'd4, 32'h0, 4'h0);
        chk("t2_be0", bus1.rd, 32'hAABBCC11);

        // Illegal accesses.
        cycle(1'b1, 1'b1, 32'd2, 32'h5, 4'hF);
        chk("t3_misalign", 32'(bus1.misalign), 32'h1);
        cycle(1'b1, 1'b0, 32'd0, 32'h0, 4'h0);
        chk("t3_rd0", bus1.rd, 32'd10);
        cycle(1'b1, 1'b0, 32'd256, 32'h0, 4'h0);
        chk("t3_oor", 32'(bus1.oor), 32'h1);
        chk("t3_oor_rd", bus1.rd, 32'h0);
        cycle(1'b1, 1'b0, 32'd257, 32'h0, 4'h0);
        idle();

        // Back-to-back reads (lat-2 stream checked by the model every cycle).
        cycle(1'b1, 1'b0, 32'd0, 32'h0, 4'h0);
        cycle(1'b1, 1'b0, 32'd4, 32'h0, 4'h0);
        cycle(1'b1, 1'b0, 32'd8, 32'h0, 4'h0);
        idle();
        idle();

        // Randomised traffic.
        for (int k = 0; k < 400; k++) begin
            kind = $urandom_range(0, 9);
            if (kind < 8)       a = 32'($urandom_range(0, DEPTH - 1) * 4);
            else if (kind == 8) a = 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
            else                a = 32'($urandom_range(NBYTES, NBYTES + 200));
            cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a, $urandom,
                  4'($urandom_range(0, 15)));
        end
        idle();
        idle();

        // Reset one cycle after a read: pending lat-2 data must never appear.
        cycle(1'b1, 1'b0, 32'd4, 32'h0, 4'h0);
        do_reset(2);
        wait_ready(CLR != 0 ? DEPTH : 1);
        idle();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
